// File: rtl/state_encoder.sv
// Serial state transmitter: on a rising edge of enable, sends a start bit, the captured state
// word MSB first, and an even-parity bit on a registered single-bit line.
module state_encoder #(
    parameter int unsigned STATE_LENGTH = 7
) (
    input  logic                    clk,
    input  logic [STATE_LENGTH-1:0] state,
    input  logic                    enable,
    output logic                    out,
    input  logic                    rst,
    output logic                    busy
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StParity} st_e;

    localparam logic [3:0] LastCnt = 4'(STATE_LENGTH);

    st_e                     st_q, st_d;
    logic [STATE_LENGTH-1:0] sh_q, sh_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    par_q, par_d;
    logic                    out_q, out_d;
    logic                    busy_q, busy_d;
    logic                    en_d_q;
    logic                    trigger;

    assign trigger = enable & ~en_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= StIdle;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            StIdle:   if (trigger) st_d = StStart;
            StStart:  st_d = StData;
            StData:   if (cnt_q == LastCnt) st_d = StParity;
            StParity: st_d = StIdle;
            default:  st_d = StIdle;
        endcase
    end

    // Registered-output and datapath next-state; cnt_q counts data bits already driven.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        par_d  = par_q;
        out_d  = 1'b0;
        busy_d = 1'b0;
        case (st_q)
            StIdle: begin
                if (trigger) begin
                    sh_d   = state;
                    cnt_d  = 4'd0;
                    par_d  = ^state;
                    out_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            StStart: begin
                out_d  = sh_q[STATE_LENGTH-1];
                sh_d   = sh_q << 1;
                cnt_d  = 4'd1;
                busy_d = 1'b1;
            end
            StData: begin
                busy_d = 1'b1;
                if (cnt_q == LastCnt) begin
                    out_d = par_q;
                end else begin
                    out_d = sh_q[STATE_LENGTH-1];
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StParity: begin
                cnt_d = 4'd0;
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

    // en_d resets high so an enable already asserted at reset release does not fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= 4'd0;
            par_q  <= 1'b0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
            en_d_q <= 1'b1;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            par_q  <= par_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            en_d_q <= enable;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_state_encoder.sv
// Directed bench for state_encoder: a 14-bit instance for most scenarios, a default 7-bit one
// for the short-frame and back-to-back trigger cases.
module tb_state_encoder;

    logic        clk;
    logic        rst;
    logic [13:0] state14;
    logic        en14;
    logic        out14;
    logic        busy14;
    logic [6:0]  state7;
    logic        en7;
    logic        out7;
    logic        busy7;

    int total;
    int bad;

    state_encoder #(.STATE_LENGTH(14)) dut14 (
        .clk    (clk),
        .state  (state14),
        .enable (en14),
        .out    (out14),
        .rst    (rst),
        .busy   (busy14)
    );

    state_encoder dut7 (
        .clk    (clk),
        .state  (state7),
        .enable (en7),
        .out    (out7),
        .rst    (rst),
        .busy   (busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic obs, input logic exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Caller raises enable before the triggering edge; step j observes the state after edge k+j.
    task automatic frame(input int which, input int len, input logic [13:0] data,
                         input logic par, input int drop_at, input int raise_at,
                         input int flip_at, input string tag);
        logic exp_o;
        logic exp_b;
        for (int j = 0; j <= len + 2; j++) begin
            tick();
            if (j == 0)             exp_o = 1'b1;
            else if (j <= len)      exp_o = data[len-j];
            else if (j == len + 1)  exp_o = par;
            else                    exp_o = 1'b0;
            exp_b = (j <= len + 1);
            check((which == 0) ? out14 : out7, exp_o, $sformatf("%s out j=%0d", tag, j));
            check((which == 0) ? busy14 : busy7, exp_b, $sformatf("%s busy j=%0d", tag, j));
            if (j == drop_at) begin
                if (which == 0) en14 = 1'b0; else en7 = 1'b0;
            end
            if (j == raise_at) begin
                if (which == 0) en14 = 1'b1; else en7 = 1'b1;
            end
            if (j == flip_at) state14 = ~state14;
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        en14    = 1'b0;
        en7     = 1'b0;
        state14 = '0;
        state7  = '0;
        tick();
        tick();
        check(out14, 1'b0, "reset out14");
        check(busy14, 1'b0, "reset busy14");
        check(out7, 1'b0, "reset out7");
        check(busy7, 1'b0, "reset busy7");
        rst = 1'b0;
        tick();

        // Held 3 cycles, re-raised at k+6 and state flipped mid-frame: frame must be unaffected.
        state14 = 14'b00011001100000;
        en14 = 1'b1;
        frame(0, 14, 14'b00011001100000, 1'b0, 2, 5, 3, "s1");
        for (int i = 0; i < 5; i++) begin
            tick();
            check(busy14, 1'b0, $sformatf("s2 no-retrigger busy i=%0d", i));
            check(out14, 1'b0, $sformatf("s2 no-retrigger out i=%0d", i));
        end
        en14 = 1'b0;
        tick();

        state14 = 14'b00000110010000;
        en14 = 1'b1;
        frame(0, 14, 14'b00000110010000, 1'b1, 0, -1, -1, "s3");
        tick();

        // Enable held high for 40 cycles yields a single frame.
        state14 = 14'b10110000000011;
        en14 = 1'b1;
        frame(0, 14, 14'b10110000000011, 1'b1, -1, -1, -1, "s4");
        for (int i = 0; i < 23; i++) begin
            tick();
            check(busy14, 1'b0, $sformatf("s4 held busy i=%0d", i));
        end
        en14 = 1'b0;
        tick();

        // Asynchronous reset while data bit 5 is on the line.
        state14 = 14'b11111111111111;
        en14 = 1'b1;
        for (int j = 0; j <= 6; j++) tick();
        check(out14, 1'b1, "s5 bit5 before reset");
        check(busy14, 1'b1, "s5 busy before reset");
        #2;
        rst = 1'b1;
        #1;
        check(out14, 1'b0, "s5 async out");
        check(busy14, 1'b0, "s5 async busy");
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check(busy14, 1'b0, $sformatf("s5 held-after-reset busy i=%0d", i));
        end
        en14 = 1'b0;
        tick();
        state14 = 14'b01000000000000;
        en14 = 1'b1;
        frame(0, 14, 14'b01000000000000, 1'b1, 0, -1, -1, "s5 rearm");

        // Default width; a trigger at k+10 starts immediately, one at k+9 is ignored.
        state7 = 7'b1100110;
        en7 = 1'b1;
        frame(1, 7, 14'b00000001100110, 1'b0, 0, -1, -1, "s6a");
        state7 = 7'b1010111;
        en7 = 1'b1;
        frame(1, 7, 14'b00000001010111, 1'b1, 0, 8, -1, "s6b");
        for (int i = 0; i < 2; i++) begin
            tick();
            check(busy7, 1'b0, $sformatf("s6 ignored trigger busy i=%0d", i));
        end
        en7 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
